// File: rtl/riscv_pkg.sv
// Shared core-wide constants for the RISC-V pipeline.
package riscv_pkg;

    localparam int                PC_WIDTH  = 32;
    localparam int                I_WIDTH   = 32;
    localparam logic [31:0]       RESET_PC  = 32'h0000_0000;
    // addi x0, x0, 0 -- canonical RISC-V no-op
    localparam logic [31:0]       NOP_INSTR = 32'h0000_0013;

endpackage : riscv_pkg

// File: rtl/fetch_skid.sv
// One-entry holding register for an instruction that arrived while decode
// was stalled. The memory output register has no enable, so a stalled word
// must be parked here before the memory overwrites it.
module fetch_skid #(
    parameter int PC_WIDTH = 32,
    parameter int I_WIDTH  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                clear,
    input  logic [PC_WIDTH-1:0] d_pc,
    input  logic [I_WIDTH-1:0]  d_instr,
    output logic                valid,
    output logic [PC_WIDTH-1:0] pc,
    output logic [I_WIDTH-1:0]  instr
);

    // Occupancy flag; clear wins over load so a redirect always empties the entry.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end
    end

    // Payload capture; contents only matter while valid is set.
    // NOTE: payload registers carry no reset -- the valid flag alone qualifies them.
    always_ff @(posedge clk) begin
        if (load && !clear) begin
            pc    <= d_pc;
            instr <= d_instr;
        end
    end

endmodule : fetch_skid

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, addresses the registered-read
// instruction memory, tags returned words with their PC and hands them to
// decode over a valid/stall handshake. Redirects flush undelivered work.
module fetch_unit #(
    parameter int                         PC_WIDTH = riscv_pkg::PC_WIDTH,
    parameter int                         I_WIDTH  = riscv_pkg::I_WIDTH,
    parameter logic [riscv_pkg::PC_WIDTH-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [PC_WIDTH-3:0] imem_addr,
    input  logic [I_WIDTH-1:0]  imem_instr,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    input  logic                stall,
    output logic                if_valid,
    output logic [PC_WIDTH-1:0] if_pc,
    output logic [I_WIDTH-1:0]  if_instr
);

    import riscv_pkg::*;

    localparam logic [PC_WIDTH-1:0] ALIGN_MASK  = ~PC_WIDTH'(3);
    localparam logic [PC_WIDTH-1:0] PC_STEP     = PC_WIDTH'(4);
    localparam logic [PC_WIDTH-1:0] RESET_ALIGN = PC_WIDTH'(RESET_PC) & ALIGN_MASK;
    localparam logic [I_WIDTH-1:0]  NOP         = I_WIDTH'(NOP_INSTR);

    // Next sequential byte PC and the tag of the word currently on imem_instr.
    logic [PC_WIDTH-1:0] pc_q;
    logic                resp_valid;
    logic [PC_WIDTH-1:0] resp_pc;

    logic                skid_valid;
    logic [PC_WIDTH-1:0] skid_pc;
    logic [I_WIDTH-1:0]  skid_instr;

    logic                src_valid;
    logic [PC_WIDTH-1:0] src_pc;
    logic [I_WIDTH-1:0]  src_instr;
    logic [PC_WIDTH-1:0] redirect_base;
    logic                issue;
    logic                skid_load;
    logic                skid_clear;

    // Output selection, issue decision and memory address (redirect is a same-cycle path).
    // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
    always_comb begin
        redirect_base = redirect_pc & ALIGN_MASK;
        src_valid     = skid_valid | resp_valid;
        src_pc        = skid_valid ? skid_pc    : resp_pc;
        src_instr     = skid_valid ? skid_instr : imem_instr;

        if_valid      = src_valid & ~redirect_valid;
        if_pc         = if_valid ? src_pc    : '0;
        if_instr      = if_valid ? src_instr : NOP;

        issue         = ~(if_valid & stall);
        imem_addr     = redirect_valid ? redirect_base[PC_WIDTH-1:2] : pc_q[PC_WIDTH-1:2];

        // Park the in-flight word only when nothing is parked yet; a redirect discards it.
        skid_load     = stall & ~skid_valid & resp_valid & ~redirect_valid;
        // Empty on redirect, or when the parked word is accepted by decode.
        skid_clear    = redirect_valid | (skid_valid & if_valid & ~stall);
    end

    // PC advance and response tagging; redirect overrides stall and sequential issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_ALIGN;
            resp_valid <= 1'b0;
            resp_pc    <= '0;
        end else if (redirect_valid) begin
            pc_q       <= redirect_base + PC_STEP;
            resp_valid <= 1'b1;
            resp_pc    <= redirect_base;
        end else if (issue) begin
            pc_q       <= pc_q + PC_STEP;
            resp_valid <= 1'b1;
            resp_pc    <= pc_q;
        end else begin
            resp_valid <= 1'b0;
        end
    end

    fetch_skid #(
        .PC_WIDTH (PC_WIDTH),
        .I_WIDTH  (I_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (skid_load),
        .clear   (skid_clear),
        .d_pc    (resp_pc),
        .d_instr (imem_instr),
        .valid   (skid_valid),
        .pc      (skid_pc),
        .instr   (skid_instr)
    );

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a stream-level reference model (one
// displayed PC that advances when accepted, restarts on redirect/reset)
// is compared against the DUT every cycle, plus directed literal checks.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [29:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    int checks = 0;
    int errors = 0;

    // Reference model state: is a word being presented, and which PC it is.
    bit          m_have;
    logic [31:0] m_cur;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
    );

    always #5 clk = ~clk;

    // Memory contents: word w holds 0xA0 + w.
    function automatic logic [31:0] mem_word(input logic [29:0] w);
        return 32'hA0 + {2'b00, w};
    endfunction

    // Registered-read instruction memory, one cycle latency, no enable.
    always @(posedge clk) imem_instr <= mem_word(imem_addr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream model: reset empties it; the cycle after reset release starts
    // presenting RESET_PC; accepted words advance by 4; a redirect restarts at the target.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_have = 1'b0;
            m_cur  = 32'h0;
        end else if (redirect_valid) begin
            m_have = 1'b1;
            m_cur  = redirect_pc & ~32'h3;
        end else if (!m_have) begin
            m_have = 1'b1;
        end else if (!stall) begin
            m_cur  = m_cur + 32'h4;
        end
    end

    // Per-cycle compare against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            logic        exp_valid;
            logic [31:0] exp_next;
            exp_valid = m_have && !redirect_valid;
            exp_next  = redirect_valid ? (redirect_pc & ~32'h3) : (m_have ? m_cur + 32'h4 : 32'h0);
            check("model_valid", {63'b0, if_valid}, {63'b0, exp_valid});
            check("model_addr", {34'b0, imem_addr}, {34'b0, exp_next[31:2]});
            if (exp_valid) begin
                check("model_pc", {32'b0, if_pc}, {32'b0, m_cur});
                check("model_instr", {32'b0, if_instr}, {32'b0, mem_word(m_cur[31:2])});
            end else begin
                check("model_nop", {32'b0, if_instr}, {32'b0, NOP});
            end
        end
    end

    task automatic step(input logic s, input logic r, input logic [31:0] rp);
        @(posedge clk);
        #1;
        stall          = s;
        redirect_valid = r;
        redirect_pc    = rp;
    endtask

    task automatic expect_word(input string name, input logic [31:0] pc, input logic [31:0] instr);
        @(negedge clk);
        check({name, "_valid"}, {63'b0, if_valid}, 64'd1);
        check({name, "_pc"}, {32'b0, if_pc}, {32'b0, pc});
        check({name, "_instr"}, {32'b0, if_instr}, {32'b0, instr});
    endtask

    task automatic expect_bubble(input string name);
        @(negedge clk);
        check({name, "_valid"}, {63'b0, if_valid}, 64'd0);
        check({name, "_instr"}, {32'b0, if_instr}, {32'b0, NOP});
    endtask

    initial begin
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Reset state.
        repeat (2) @(posedge clk);
        #2;
        check("rst_valid", {63'b0, if_valid}, 64'd0);
        check("rst_pc", {32'b0, if_pc}, 64'd0);
        check("rst_instr", {32'b0, if_instr}, {32'b0, NOP});
        check("rst_addr", {34'b0, imem_addr}, 64'd0);

        // Release: first cycle issues, words 0..3 follow back to back.
        @(posedge clk);
        #1 rst_n = 1'b1;
        expect_bubble("first");
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 32'h0);
            expect_word("seq", 32'(i * 4), 32'hA0 + 32'(i));
        end

        // Three-cycle stall at 16: held, then accepted, then 20.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0);
            expect_word("stall_hold", 32'd16, 32'hA4);
            check("stall_addr", {34'b0, imem_addr}, 64'd5);
        end
        step(1'b0, 1'b0, 32'h0);
        expect_word("stall_rel", 32'd16, 32'hA4);
        step(1'b0, 1'b0, 32'h0);
        expect_word("stall_next", 32'd20, 32'hA5);

        // Redirect with stall while skid is full; unaligned target 0x43.
        step(1'b1, 1'b0, 32'h0);
        expect_word("skid_a", 32'd24, 32'hA6);
        step(1'b1, 1'b0, 32'h0);
        expect_word("skid_b", 32'd24, 32'hA6);
        step(1'b1, 1'b1, 32'h43);
        expect_bubble("redir_stall");
        check("redir_addr", {34'b0, imem_addr}, 64'h10);
        step(1'b0, 1'b0, 32'h0);
        expect_word("redir_tgt", 32'h40, 32'hB0);
        step(1'b0, 1'b0, 32'h0);
        expect_word("redir_seq", 32'h44, 32'hB1);

        // PC wrap at the top of the address space.
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        expect_bubble("wrap_redir");
        step(1'b0, 1'b0, 32'h0);
        expect_word("wrap_top", 32'hFFFF_FFFC, 32'h4000_009F);
        step(1'b0, 1'b0, 32'h0);
        expect_word("wrap_zero", 32'h0, 32'hA0);

        // Asynchronous reset during a stall with a full skid.
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", {63'b0, if_valid}, 64'd0);
        check("arst_instr", {32'b0, if_instr}, {32'b0, NOP});
        check("arst_addr", {34'b0, imem_addr}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stall = 1'b0;
        expect_bubble("arst_first");
        step(1'b0, 1'b0, 32'h0);
        expect_word("arst_restart", 32'h0, 32'hA0);

        // Randomized traffic checked by the per-cycle model.
        for (int n = 0; n < 4000; n++) begin
            logic s;
            logic r;
            s = ($urandom_range(0, 99) < 35);
            r = ($urandom_range(0, 99) < 6);
            step(s, r, $urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fetch_unit
